// File: rtl/ijtag_scan_master.sv
// IJTAG scan initiator: runs capture / shift / update on the scan network,
// shifting WrData out LSB-first and collecting ScanOut into RdData.
module ijtag_scan_master #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 6
) (
  input  logic               CLK,
  input  logic               RstBar,
  input  logic               Start,
  input  logic [CNT_W-1:0]   Len,
  input  logic [MAX_LEN-1:0] WrData,
  input  logic               ScanOut,
  output logic               Select,
  output logic               CaptureEn,
  output logic               ShiftEn,
  output logic               UpdateEn,
  output logic               ScanIn,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [MAX_LEN-1:0] RdData,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SHIFT   = 3'd2,
    S_UPDATE  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [MAX_LEN-1:0] sh_q, sh_d, col_q, col_d, rd_q, rd_d;
  logic               scan_in_q, scan_in_d, err_q, err_d;
  logic               select_q, select_d, capture_q, capture_d;
  logic               shift_q, shift_d, update_q, update_d, done_q, done_d;
  logic               len_ok, last_bit;

  assign len_ok   = (Len != '0) && (Len <= CNT_W'(MAX_LEN));
  assign last_bit = (cnt_q == len_q - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    col_d     = col_q;
    rd_d      = rd_q;
    scan_in_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (len_ok) begin
            len_d   = Len;
            sh_d    = WrData;
            cnt_d   = '0;
            col_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        state_d   = S_SHIFT;
        scan_in_d = sh_q[0];
        sh_d      = sh_q >> 1;
      end
      S_SHIFT: begin
        // Bit i lands at position i, so bits at or above Len stay zero.
        col_d = col_q | ({{(MAX_LEN-1){1'b0}}, ScanOut} << cnt_q);
        if (last_bit) begin
          state_d = S_UPDATE;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          scan_in_d = sh_q[0];
          sh_d      = sh_q >> 1;
        end
      end
      S_UPDATE: begin
        rd_d    = col_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    select_d  = (state_d == S_CAPTURE) || (state_d == S_SHIFT) || (state_d == S_UPDATE);
    capture_d = (state_d == S_CAPTURE);
    shift_d   = (state_d == S_SHIFT);
    update_d  = (state_d == S_UPDATE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RstBar) begin
    if (!RstBar) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      col_q     <= '0;
      rd_q      <= '0;
      scan_in_q <= 1'b0;
      err_q     <= 1'b0;
      select_q  <= 1'b0;
      capture_q <= 1'b0;
      shift_q   <= 1'b0;
      update_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      col_q     <= col_d;
      rd_q      <= rd_d;
      scan_in_q <= scan_in_d;
      err_q     <= err_d;
      select_q  <= select_d;
      capture_q <= capture_d;
      shift_q   <= shift_d;
      update_q  <= update_d;
      done_q    <= done_d;
    end
  end

  assign Select    = select_q;
  assign CaptureEn = capture_q;
  assign ShiftEn   = shift_q;
  assign UpdateEn  = update_q;
  assign ScanIn    = scan_in_q;
  assign Busy      = select_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign RdData    = rd_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ijtag_scan_master.sv
// Bench for ijtag_scan_master: a variable-length scan network model, table
// vectors, randomized transactions and reset corner sequences.
module tb_ijtag_scan_master;
  localparam int MAX_LEN = 32;
  localparam int CNT_W   = 6;

  // Handshake: Start is a request sampled only when the master is idle;
  // the master answers with Done (accepted) or Err (rejected) pulses.
  logic               CLK = 1'b0;
  logic               RstBar = 1'b0;
  logic               Start = 1'b0;
  logic [CNT_W-1:0]   Len = '0;
  logic [MAX_LEN-1:0] WrData = '0;
  logic               ScanOut;
  logic               Select, CaptureEn, ShiftEn, UpdateEn, ScanIn, Busy, Done, Err;
  logic [MAX_LEN-1:0] RdData;
  logic [2:0]         state_dbg;
  logic [7:0]         ctl;

  ijtag_scan_master #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RstBar(RstBar), .Start(Start), .Len(Len), .WrData(WrData),
    .ScanOut(ScanOut), .Select(Select), .CaptureEn(CaptureEn), .ShiftEn(ShiftEn),
    .UpdateEn(UpdateEn), .ScanIn(ScanIn), .Busy(Busy), .Done(Done), .Err(Err),
    .RdData(RdData), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  assign ctl = {Select, CaptureEn, ShiftEn, UpdateEn, ScanIn, Busy, Done, Err};

  function automatic logic [31:0] len_mask(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Scan network: loads cap_val on capture, shifts ScanIn into bit net_len-1.
  logic [31:0] net_q = '0;
  logic [31:0] cap_val = '0;
  int          net_len = 8;
  assign ScanOut = net_q[0];
  always @(posedge CLK) begin
    if (CaptureEn) net_q <= cap_val & len_mask(net_len);
    else if (ShiftEn) net_q <= (net_q >> 1) | (32'(ScanIn) << (net_len - 1));
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rd_exp = '0;
  logic [31:0] exp_q[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [5:0] len, input logic [31:0] wr, input logic [31:0] cap,
                         input bit poke, input bit exp_err, input logic [31:0] exp_rd,
                         input string tag);
    logic [7:0]  e;
    logic [31:0] rd_before;
    int          ncyc;
    rd_before = rd_exp;
    exp_q.push_back(exp_rd);
    @(negedge CLK);
    Start = 1'b1; Len = len; WrData = wr; cap_val = cap;
    if (!exp_err) net_len = int'(len);
    @(posedge CLK);
    #1 Start = 1'b0; Len = CNT_W'($urandom); WrData = $urandom;
    ncyc = exp_err ? 1 : int'(len) + 3;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge CLK);
      if (exp_err) begin
        e = 8'b0000_0001;
      end else begin
        e[7] = (c <= len + 2);
        e[6] = (c == 1);
        e[5] = (c >= 2) && (c <= len + 1);
        e[4] = (c == len + 2);
        e[3] = e[5] ? wr[c-2] : 1'b0;
        e[2] = (c <= len + 2);
        e[1] = (c == len + 3);
        e[0] = 1'b0;
      end
      cmp($sformatf("%s ctl c%0d", tag, c), {56'b0, ctl}, {56'b0, e});
      cmp($sformatf("%s rd c%0d", tag, c), {32'b0, RdData},
          {32'b0, (!exp_err && c == ncyc) ? exp_rd : rd_before});
      if (poke && !exp_err && (c == 3 || c == ncyc)) begin
        Start = 1'b1; Len = CNT_W'($urandom_range(1, 32)); WrData = $urandom;
      end
      @(posedge CLK);
      #1 Start = 1'b0;
    end
    @(negedge CLK);
    cmp($sformatf("%s idle ctl", tag), {56'b0, ctl}, 64'b0);
    cmp($sformatf("%s idle rd", tag), {32'b0, RdData}, {32'b0, exp_q.pop_front()});
    if (!exp_err) cmp($sformatf("%s net", tag), {32'b0, net_q}, {32'b0, wr & len_mask(int'(len))});
    rd_exp = exp_rd;
  endtask

  typedef struct {
    logic [5:0]  len;
    logic [31:0] wr;
    logic [31:0] cap;
    bit          poke;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'd8,  32'h0000_00A5, 32'h0000_003C, 1'b0, 1'b0, 32'h0000_003C};
    vecs[1] = '{6'd0,  32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_003C};
    vecs[2] = '{6'd33, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_003C};
    vecs[3] = '{6'd32, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
    vecs[4] = '{6'd5,  32'h0000_0015, 32'h0000_000A, 1'b1, 1'b0, 32'h0000_000A};
    vecs[5] = '{6'd1,  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0001};
    vecs[6] = '{6'd63, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001};
    vecs[7] = '{6'd16, 32'h0000_CAFE, 32'h1234_BEEF, 1'b1, 1'b0, 32'h0000_BEEF};

    // Reset held with random inputs, then released with Start low.
    for (int i = 0; i < 3; i++) begin
      Start = 1'($urandom); Len = CNT_W'($urandom); WrData = $urandom;
      @(negedge CLK);
      cmp($sformatf("reset ctl %0d", i), {56'b0, ctl}, 64'b0);
      cmp($sformatf("reset rd %0d", i), {32'b0, RdData}, 64'b0);
    end
    Start = 1'b0;
    RstBar = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      cmp($sformatf("post-reset ctl %0d", i), {56'b0, ctl}, 64'b0);
    end

    for (int v = 0; v < 8; v++)
      run_txn(vecs[v].len, vecs[v].wr, vecs[v].cap, vecs[v].poke, vecs[v].exp_err,
              vecs[v].exp_rd, $sformatf("vec%0d", v));

    // Reset dropped during the third shift cycle of a Len=8 transaction.
    @(negedge CLK);
    Start = 1'b1; Len = 6'd8; WrData = $urandom; cap_val = $urandom; net_len = 8;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (4) @(negedge CLK);
    cmp("midrst shifting", {63'b0, ShiftEn}, 64'd1);
    RstBar = 1'b0;
    #1;
    cmp("midrst ctl", {56'b0, ctl}, 64'b0);
    cmp("midrst rd", {32'b0, RdData}, 64'b0);
    rd_exp = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      cmp($sformatf("midrst hold %0d", i), {56'b0, ctl}, 64'b0);
    end
    RstBar = 1'b1;
    @(negedge CLK);
    cmp("midrst released", {56'b0, ctl}, 64'b0);
    run_txn(6'd4, 32'h0000_0009, 32'h0000_0006, 1'b0, 1'b0, 32'h0000_0006, "after_rst");

    // Randomized transactions, expected results from the network's capture value.
    for (int i = 0; i < 24; i++) begin
      logic [5:0]  l;
      logic [31:0] w, cp, er;
      bit          ok;
      l  = 6'($urandom_range(0, 40));
      w  = $urandom;
      cp = $urandom;
      ok = (l >= 1) && (l <= MAX_LEN);
      er = ok ? (cp & len_mask(int'(l))) : rd_exp;
      run_txn(l, w, cp, 1'($urandom), !ok, er, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ijtag_scan_master.md
Name: ijtag_scan_master

Overview:
Initiator side of our IJTAG scan network. It drives the Select / CaptureEn / ShiftEn / UpdateEn / ScanIn controls that our SIB and TDR segments (built from D_FF and MUX2_1 cells) respond to. A parallel write vector is shifted serially into the network while ScanOut is collected into a parallel read vector. It sits between the secure-access controller and the root of the scan network.

Parameters:
MAX_LEN, 32, maximum scan length in bits (width of WrData/RdData)
CNT_W, 6, width of Len and of the internal bit counter; must hold MAX_LEN

Ports:
CLK  input  1  system clock; all state updates on posedge
RstBar  input  1  asynchronous active-low reset
Start  input  1  request a scan transaction; sampled only in IDLE
Len  input  CNT_W  number of bits to shift; valid range 1..MAX_LEN
WrData  input  MAX_LEN  data to shift in; bit 0 is shifted first
ScanOut  input  1  serial data returned from the network
Select  output  1  network segment select
CaptureEn  output  1  capture strobe to the network
ShiftEn  output  1  shift enable to the network
UpdateEn  output  1  update strobe to the network
ScanIn  output  1  serial data to the network
Busy  output  1  transaction in progress
Done  output  1  one-cycle completion pulse
Err  output  1  one-cycle pulse on a rejected Start
RdData  output  MAX_LEN  data collected by the last completed transaction

Behaviour:
- Clock and reset: one clock (CLK). RstBar is asynchronous and active-low.
- Reset: RstBar low forces IDLE immediately.
  - All outputs go to 0, including RdData.
  - The latched Len/WrData and the bit counter are cleared.
  - This applies mid-transaction too; no partial UpdateEn is issued.
- All outputs are registered (Moore-style) and decoded from state.
- States: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- IDLE: all outputs 0 except RdData, which holds its value.
  - Start=1 with 1<=Len<=MAX_LEN at edge k: latch Len and WrData, clear the counter, go to CAPTURE.
  - Start=1 with Len=0 or Len>MAX_LEN: stay in IDLE, Err=1 for exactly the next cycle, nothing else changes.
- CAPTURE (1 cycle): Select=1, CaptureEn=1, Busy=1. Go to SHIFT.
- SHIFT (exactly Len cycles, index i=0..Len-1): Select=1, ShiftEn=1, Busy=1.
  - ScanIn = latched WrData[i].
  - At the edge ending cycle i, ScanOut is sampled into internal collect bit i.
  - After the Len-th sample, go to UPDATE.
- UPDATE (1 cycle): Select=1, UpdateEn=1, Busy=1, ScanIn=0.
  - At the edge leaving UPDATE, RdData is loaded with the collect register.
  - Bits Len..MAX_LEN-1 of the loaded value are 0.
- DONE (1 cycle): Done=1, Busy=0, Select=0. Go to IDLE.
  - Start is ignored in DONE.
- Latency: Start sampled at edge k gives:
  - CaptureEn in cycle k+1
  - ShiftEn in cycles k+2..k+Len+1
  - UpdateEn in cycle k+Len+2
  - Done in cycle k+Len+3
  - Total Len+3 cycles.
- Start is ignored whenever the state is not IDLE. It is not queued.
- WrData and Len changes after latch do not affect the transaction in flight.
- Control exclusivity: at most one of CaptureEn/ShiftEn/UpdateEn is 1 in any cycle. Select=1 exactly when any of them is 1.
- ScanIn=0 in every state except SHIFT.
- Counter: CNT_W bits, no wrap. Comparison is counter == Len-1 in SHIFT.
- RdData changes only at the UPDATE->DONE edge or on reset.

Test Plan:
- Reset: assert RstBar=0 with random inputs -> every output 0; release -> state IDLE, outputs stay 0 until Start.
- Basic 8-bit transaction, with an 8-bit network model (captures 0x3C on CaptureEn; shift inserts ScanIn at MSB, ScanOut = LSB):
  - Stimulus: Start at edge k, Len=8, WrData=0xA5.
  - Required: CaptureEn in cycle k+1; ShiftEn in cycles k+2..k+9; ScanIn sequence 1,0,1,0,0,1,0,1.
  - Required: UpdateEn in cycle k+10; model holds 0xA5; Done in cycle k+11; RdData=0x0000003C.
- Invalid length: Start with Len=0, then with Len=33 -> Err pulses one cycle each; Select/CaptureEn/Busy stay 0; RdData unchanged.
- Full length: Len=32, WrData=0xDEADBEEF, ScanOut looped from a 32-stage model preloaded with 0x12345678 -> 32 ShiftEn cycles; Done at k+35; RdData=0x12345678.
- Start while busy: pulse Start during SHIFT and during DONE -> ignored; exactly one CaptureEn and one Done per accepted Start.
- Reset mid-shift: drop RstBar in the 3rd SHIFT cycle -> outputs 0 asynchronously, no UpdateEn, RdData=0; a following Len=4 transaction completes normally with Done at k+7.
